mdu_step_sequencer: RTL and testbench
=====================================

// Module: mdu_step_sequencer
// PURPOSE
//  Control FSM that drives the iterative datapath of the multiply/divide unit.
//  Accepts an operation over a valid/ready start handshake and pulses operand load.
//  Issues one step enable per iteration, using an internal iteration counter that it
//  loads, enables and terminates, then presents a done valid/ready handshake.
//  Sits between the MDU request interface and the shift/add/subtract datapath.
// PARAMETERS
//  WIDTH    6   width of iteration count and step index (max 2**WIDTH-1 steps)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous reset, active-high
//  abort        in   1      synchronous abandon of current op
//  start_valid  in   1      request valid
//  start_ready  out  1      sequencer can accept a request (IDLE only)
//  op_div       in   1      1=division, 0=multiplication; sampled on accept
//  n_steps      in   WIDTH  iterations to run; sampled on accept
//  stall        in   1      datapath hold; freezes STEP state and counter
//  load_operands out 1      one-cycle pulse: datapath loads operands
//  step_en      out  1      datapath performs iteration step_idx this cycle
//  step_idx     out  WIDTH  current iteration, 0 .. n_steps-1
//  restore_en   out  1      one-cycle division remainder-correction pulse
//  done_valid   out  1      result ready; held until done_ready
//  done_ready   in   1      consumer accepts result
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - rst: state=IDLE, counter=0, captured op/n_steps=0. All outputs 0 except start_ready=1.
//  - Outputs are Moore-decoded from state; step_en = (state==STEP) & ~stall.
//  - States: IDLE, LOAD, STEP, FIX, DONE.
//  - IDLE: start_ready=1. Accept when start_valid&start_ready: capture op_div, n_steps -> LOAD.
//  - LOAD: load_operands=1, counter cleared to 0. If captured n_steps==0 -> DONE, else -> STEP.
//  - STEP: step_idx=counter. Each non-stalled cycle, counter increments.
//    On the cycle where counter==n_steps-1 and ~stall (tc), exit to FIX if op_div else DONE.
//    stall=1: state, counter and step_idx hold; step_en=0.
//  - FIX: restore_en=1 for one cycle -> DONE. Entered only for division with n_steps>0.
//  - DONE: done_valid=1 until done_ready sampled high -> IDLE.
//    No same-cycle re-accept: start_ready rises the cycle after the done handshake.
//  - Latency, accept edge to first done_valid cycle, no stalls:
//    mul n_steps+2 cycles, div n_steps+3 cycles, n_steps=0 gives 2 cycles.
//    Each stalled cycle adds exactly 1 cycle.
//  - abort (sync, priority over all but rst): next state IDLE, counter cleared,
//    no done_valid, restore_en or load_operands generated. abort in IDLE is a no-op;
//    a start accepted in the same cycle as abort is dropped.
//  - rst asserted mid-operation: immediate return to the reset state; no partial handshake.
//  - Counter never wraps: tc check precedes increment; n_steps=2**WIDTH-1 runs fully.
//  - start_valid and op inputs are ignored outside IDLE.
// STRUCTURE
//  - mdu_seq_pkg: typedef enum logic [2:0] seq_state_t {IDLE,LOAD,STEP,FIX,DONE};
//    typedef enum logic {OP_MUL,OP_DIV} mdu_op_t.
//  - Sub-module iter_counter #(WIDTH): up counter with clr, en, tc-at-threshold output.
//  - This module holds the FSM, the capture registers and the output decode.
// TESTING
//  - rst pulse mid-STEP (mul, n_steps=10, at idx 4) -> IDLE, start_ready=1,
//    step_en=0, busy=0 asynchronously.
//  - mul, n_steps=4, done_ready=1 -> load_operands pulse, step_idx 0,1,2,3 with step_en,
//    no restore_en, done_valid 6 cycles after accept.
//  - div, n_steps=3, stall high 2 cycles at idx 1 -> idx 1 held 3 cycles,
//    restore_en once, done_valid 8 cycles after accept.
//  - n_steps=0 (mul and div) -> load_operands, then done_valid; no step_en or restore_en.
//  - done_ready low 5 cycles -> done_valid held, start_ready=0; new start_valid
//    accepted only the cycle after the handshake.
//  - abort at idx 2 -> IDLE next cycle, no done_valid; next op n_steps=2 starts idx at 0.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// rtl/mdu_seq_pkg.sv - shared types for the MDU step sequencer
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        STEP = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } mdu_op_t;

endpackage

// File: rtl/iter_counter.sv
// rtl/iter_counter.sv - iteration up counter with clear, enable and terminal-count flag
module iter_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/mdu_step_sequencer.sv
// rtl/mdu_step_sequencer.sv - control FSM sequencing the iterative multiply/divide datapath
module mdu_step_sequencer
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_div,
    input  logic [WIDTH-1:0] n_steps,
    input  logic             stall,
    output logic             load_operands,
    output logic             step_en,
    output logic [WIDTH-1:0] step_idx,
    output logic             restore_en,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    seq_state_t       state;
    seq_state_t       state_d;
    mdu_op_t          op_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             cnt_clr;
    logic             cnt_en;
    logic             accept;

    assign accept = (state == IDLE) && start_valid && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= OP_MUL;
            n_q  <= '0;
        end else if (accept) begin
            op_q <= mdu_op_t'(op_div);
            n_q  <= n_steps;
        end
    end

    // Increment is suppressed on the terminal cycle so the counter cannot wrap at full range.
    always_comb begin
        state_d = state;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) state_d = LOAD;
                end
                LOAD: begin
                    cnt_clr = 1'b1;
                    state_d = (n_q == '0) ? DONE : STEP;
                end
                STEP: begin
                    if (!stall) begin
                        if (tc) state_d = (op_q == OP_DIV) ? FIX : DONE;
                        else    cnt_en  = 1'b1;
                    end
                end
                FIX: begin
                    state_d = DONE;
                end
                DONE: begin
                    if (done_ready) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    iter_counter #(
        .WIDTH(WIDTH)
    ) u_iter_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (n_q - WIDTH'(1)),
        .count(count),
        .tc   (tc)
    );

    assign start_ready   = (state == IDLE);
    assign load_operands = (state == LOAD);
    assign step_en       = (state == STEP) && !stall;
    assign step_idx      = (state == STEP) ? count : '0;
    assign restore_en    = (state == FIX);
    assign done_valid    = (state == DONE);
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mdu_step_sequencer.sv
// tb/tb_mdu_step_sequencer.sv - randomized trace-based bench for mdu_step_sequencer
module tb_mdu_step_sequencer;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         abort;
    logic         start_valid;
    logic         start_ready;
    logic         op_div;
    logic [W-1:0] n_steps;
    logic         stall;
    logic         load_operands;
    logic         step_en;
    logic [W-1:0] step_idx;
    logic         restore_en;
    logic         done_valid;
    logic         done_ready;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_step_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .abort        (abort),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op_div       (op_div),
        .n_steps      (n_steps),
        .stall        (stall),
        .load_operands(load_operands),
        .step_en      (step_en),
        .step_idx     (step_idx),
        .restore_en   (restore_en),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .busy         (busy)
    );

    typedef struct {
        logic         sv, od, ab, st, dr;
        logic [W-1:0] n;
        logic         sr, ld, se, rs, dv, bz;
        logic [W-1:0] idx;
        int           tag;
    } ent_t;

    ent_t tr[$];
    int   lat[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t busy_ent();
        ent_t e;
        e.sv = 1'($urandom_range(0, 1)); e.od = 1'($urandom_range(0, 1));
        e.n  = W'($urandom);             e.ab = 1'b0;
        e.st = 1'($urandom_range(0, 1)); e.dr = 1'($urandom_range(0, 1));
        e.sr = 1'b0; e.ld = 1'b0; e.se = 1'b0; e.rs = 1'b0; e.dv = 1'b0; e.bz = 1'b1;
        e.idx = '0; e.tag = -1;
        return e;
    endfunction

    function automatic ent_t idle_ent(input logic sv, input logic od, input logic [W-1:0] n,
                                      input logic ab);
        ent_t e;
        e = busy_ent();
        e.sv = sv; e.od = od; e.n = n; e.ab = ab;
        e.sr = 1'b1; e.bz = 1'b0;
        return e;
    endfunction

    // Expected cycle-by-cycle trace of one operation, built from the behavioural rules.
    task automatic build(input bit od, input int n, input int pct, input int sidx,
                         input int scnt, input int rdel, input int ab_at);
        ent_t t[$];
        ent_t e;
        int   stalls = 0;
        e = idle_ent(1'b1, od, W'(n), 1'b0);
        e.tag = lat.size();
        t.push_back(e);
        e = busy_ent(); e.ld = 1'b1; t.push_back(e);
        for (int i = 0; i < n; i++) begin
            int k = (i == sidx) ? scnt : 0;
            while (k > 0 || (pct > 0 && $urandom_range(0, 99) < pct)) begin
                e = busy_ent(); e.st = 1'b1; e.idx = W'(i); t.push_back(e);
                stalls++;
                if (k > 0) k--;
            end
            e = busy_ent(); e.st = 1'b0; e.se = 1'b1; e.idx = W'(i); t.push_back(e);
        end
        if (od && n > 0) begin
            e = busy_ent(); e.rs = 1'b1; t.push_back(e);
        end
        for (int j = 0; j < rdel; j++) begin
            e = busy_ent(); e.dv = 1'b1; e.dr = 1'b0; t.push_back(e);
        end
        e = busy_ent(); e.dv = 1'b1; e.dr = 1'b1; t.push_back(e);
        lat.push_back(n + 2 + ((od && n > 0) ? 1 : 0) + stalls);
        if (ab_at > 0 && ab_at < t.size()) begin
            while (t.size() > ab_at + 1) void'(t.pop_back());
            e = t[ab_at]; e.ab = 1'b1; t[ab_at] = e;
        end
        foreach (t[i]) tr.push_back(t[i]);
    endtask

    task automatic play();
        ent_t e;
        int   acc_c = 0;
        int   lat_exp = 0;
        bit   pend = 0;
        for (int c = 0; c < tr.size(); c++) begin
            @(negedge clk);
            e = tr[c];
            start_valid = e.sv; op_div = e.od; n_steps = e.n;
            abort = e.ab; stall = e.st; done_ready = e.dr;
            #1;
            chk($sformatf("c%0d start_ready", c), 32'(start_ready), 32'(e.sr));
            chk($sformatf("c%0d load_operands", c), 32'(load_operands), 32'(e.ld));
            chk($sformatf("c%0d step_en", c), 32'(step_en), 32'(e.se));
            if (e.se || e.st && e.bz && !e.ld && !e.rs && !e.dv)
                chk($sformatf("c%0d step_idx", c), 32'(step_idx), 32'(e.idx));
            chk($sformatf("c%0d restore_en", c), 32'(restore_en), 32'(e.rs));
            chk($sformatf("c%0d done_valid", c), 32'(done_valid), 32'(e.dv));
            chk($sformatf("c%0d busy", c), 32'(busy), 32'(e.bz));
            if (e.tag >= 0) begin
                acc_c = c; lat_exp = lat[e.tag]; pend = 1;
            end
            if (done_valid && pend) begin
                chk($sformatf("c%0d latency", c), 32'(c - acc_c), 32'(lat_exp));
                pend = 0;
            end
        end
    endtask

    initial begin
        bit hit;
        rst = 1'b1; abort = 1'b0; start_valid = 1'b0; op_div = 1'b0;
        n_steps = '0; stall = 1'b0; done_ready = 1'b0;
        #3;
        chk("reset start_ready", 32'(start_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done_valid", 32'(done_valid), 32'd0);
        chk("reset load_operands", 32'(load_operands), 32'd0);
        chk("reset step_en", 32'(step_en), 32'd0);
        chk("reset step_idx", 32'(step_idx), 32'd0);
        chk("reset restore_en", 32'(restore_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        build(0, 4, 0, -1, 0, 0, -1);
        build(1, 3, 0, 1, 2, 0, -1);
        build(0, 0, 0, -1, 0, 0, -1);
        build(1, 0, 0, -1, 0, 1, -1);
        build(0, 3, 0, -1, 0, 5, -1);
        build(1, 2, 0, -1, 0, 0, -1);
        build(0, 6, 0, -1, 0, 0, 4);
        build(0, 2, 0, -1, 0, 0, -1);
        tr.push_back(idle_ent(1'b1, 1'b1, W'(5), 1'b1));
        tr.push_back(idle_ent(1'b0, 1'b0, W'(0), 1'b0));
        build(1, 63, 10, -1, 0, 1, -1);
        build(0, 63, 0, -1, 0, 0, -1);
        for (int t = 0; t < 60; t++) begin
            int r = $urandom_range(0, 9);
            int n = (r < 8) ? $urandom_range(0, 7) : (r == 8) ? 63 : $urandom_range(0, 20);
            int ab = ($urandom_range(0, 6) == 0) ? $urandom_range(1, n + 4) : -1;
            int rd = ($urandom_range(0, 4) == 0) ? 5 : $urandom_range(0, 2);
            build($urandom_range(0, 1), n, ($urandom_range(0, 1) == 1) ? 30 : 0, -1, 0, rd, ab);
            for (int g = $urandom_range(0, 2); g > 0; g--)
                tr.push_back(idle_ent(1'b0, 1'($urandom), W'($urandom),
                                      1'($urandom_range(0, 3) == 0)));
        end
        tr.push_back(idle_ent(1'b0, 1'b0, W'(0), 1'b0));
        tr.push_back(idle_ent(1'b0, 1'b0, W'(0), 1'b0));
        play();

        @(negedge clk);
        start_valid = 1'b1; op_div = 1'b0; n_steps = W'(10); abort = 1'b0;
        stall = 1'b0; done_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        hit = 0;
        for (int k = 0; k < 30 && !hit; k++) begin
            #1;
            if (step_en && step_idx == W'(4)) hit = 1;
            else @(negedge clk);
        end
        chk("rst reached idx4", 32'(hit), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async start_ready", 32'(start_ready), 32'd1);
        chk("rst async step_en", 32'(step_en), 32'd0);
        chk("rst async busy", 32'(busy), 32'd0);
        chk("rst async step_idx", 32'(step_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post rst done_valid", 32'(done_valid), 32'd0);
        chk("post rst busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
